// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one HD44780-style LCD write port between two requesters.
// Define LCD_INIT_EN to issue the power-up command sequence 38,0C,06,01 after reset.
module lcd_write_arbiter #(
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 12,
   parameter int HOLD_CYC  = 2,
   parameter int EXEC_CYC  = 2000,
   parameter int CLR_CYC   = 80000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       rs0,
   input  logic [7:0] data0,
   output logic       ack0,
   input  logic       req1,
   input  logic       rs1,
   input  logic [7:0] data1,
   output logic       ack1,
   output logic       en,
   output logic [7:0] lcd_data,
   output logic       rs,
   output logic       rw,
   output logic       on,
   output logic       busy
);

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Clear and return-home need the long execution wait.
   function automatic logic is_clear_cmd(input logic rs_v, input logic [7:0] d);
      return (rs_v == 1'b0) && ((d == 8'h01) || (d == 8'h02) || (d == 8'h03));
   endfunction

   localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, PULSE_CYC),
                                            max_int(HOLD_CYC, EXEC_CYC)), CLR_CYC);
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_WAIT  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic             prio_q, prio_d;
   logic             owner_q, owner_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             en_q, en_d;
   logic             busy_q, busy_d;
   logic             on_q;

   logic             elig0_s, elig1_s, gnt_vld_s, gnt_sel_s;
   logic             init_act_s, init_last_s;
   logic [7:0]       init_cmd_s, init_nxt_s;

`ifdef LCD_INIT_EN
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      logic [7:0] c;
      case (idx)
         2'd0:    c = 8'h38;
         2'd1:    c = 8'h0C;
         2'd2:    c = 8'h06;
         2'd3:    c = 8'h01;
         default: c = 8'h01;
      endcase
      return c;
   endfunction

   logic       init_act_q, init_act_d;
   logic [1:0] init_idx_q, init_idx_d;
   logic       init_adv_s;

   assign init_act_s  = init_act_q;
   assign init_last_s = (init_idx_q == 2'd3);
   assign init_cmd_s  = init_cmd(init_idx_q);
   assign init_nxt_s  = init_cmd(init_idx_q + 2'd1);
   assign init_adv_s  = (state_q == ST_WAIT) && (cnt_q == CNT_ZERO) && init_act_q;

   // Init sequence progress: advance on each completed init command.
   always_comb begin
      init_act_d = init_act_q;
      init_idx_d = init_idx_q;
      if (init_adv_s) begin
         if (init_idx_q == 2'd3) begin
            init_act_d = 1'b0;
         end else begin
            init_idx_d = init_idx_q + 2'd1;
         end
      end else begin
         init_idx_d = init_idx_q;
      end
   end

   // Init sequence registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_act_q <= 1'b1;
         init_idx_q <= 2'd0;
      end else begin
         init_act_q <= init_act_d;
         init_idx_q <= init_idx_d;
      end
   end
`else
   assign init_act_s  = 1'b0;
   assign init_last_s = 1'b1;
   assign init_cmd_s  = 8'h00;
   assign init_nxt_s  = 8'h00;
`endif

   // Round-robin pick; a requester is masked in its own ack cycle.
   always_comb begin
      elig0_s   = req0 & ~ack0_q;
      elig1_s   = req1 & ~ack1_q;
      gnt_vld_s = elig0_s | elig1_s;
      if (elig0_s && elig1_s) begin
         gnt_sel_s = prio_q;
      end else if (elig1_s) begin
         gnt_sel_s = 1'b1;
      end else begin
         gnt_sel_s = 1'b0;
      end
   end

   // Write sequencer next-state and output decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rs_d    = rs_q;
      data_d  = data_q;
      prio_d  = prio_q;
      owner_d = owner_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (init_act_s) begin
               rs_d    = 1'b0;
               data_d  = init_cmd_s;
               state_d = ST_SETUP;
               cnt_d   = SETUP_LD;
            end else if (gnt_vld_s) begin
               owner_d = gnt_sel_s;
               prio_d  = ~gnt_sel_s;
               rs_d    = gnt_sel_s ? rs1 : rs0;
               data_d  = gnt_sel_s ? data1 : data0;
               state_d = ST_SETUP;
               cnt_d   = SETUP_LD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (cnt_q == CNT_ZERO) begin
               state_d = ST_PULSE;
               cnt_d   = PULSE_LD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_PULSE: begin
            if (cnt_q == CNT_ZERO) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (cnt_q == CNT_ZERO) begin
               state_d = ST_WAIT;
               cnt_d   = is_clear_cmd(rs_q, data_q) ? CLR_LD : EXEC_LD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_WAIT: begin
            if (cnt_q != CNT_ZERO) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (init_act_s && !init_last_s) begin
               // Init commands chain directly, with no idle cycle between them.
               rs_d    = 1'b0;
               data_d  = init_nxt_s;
               state_d = ST_SETUP;
               cnt_d   = SETUP_LD;
            end else if (init_act_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_IDLE;
               ack0_d  = ~owner_q;
               ack1_d  = owner_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
      en_d   = (state_d == ST_PULSE);
      busy_d = (state_d != ST_IDLE);
   end

   // Sequencer state and registered LCD/handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= CNT_ZERO;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         on_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         on_q    <= 1'b1;
      end
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign en       = en_q;
   assign lcd_data = data_q;
   assign rs       = rs_q;
   assign rw       = 1'b0;
   assign on       = on_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: directed timing scenarios plus randomized two-requester
// traffic checked against a transaction-level model of grants and completion times.
module tb_lcd_write_arbiter;
   localparam int S = 2, P = 4, H = 2, E = 10, C = 40;
   localparam int MAXC = 3000;
   localparam int BIG = 1 << 30;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, rs0, req1, rs1;
   logic [7:0] data0, data1;
   logic       ack0, ack1, en, rs, rw, on, busy;
   logic [7:0] lcd_data;

   lcd_write_arbiter #(
      .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .EXEC_CYC(E), .CLR_CYC(C)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
      .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
      .en(en), .lcd_data(lcd_data), .rs(rs), .rw(rw), .on(on), .busy(busy)
   );

   always #5 clk = ~clk;

   // observed vector: {on, rw, busy, en, ack1, ack0, rs, lcd_data}
   wire [14:0] obs_v = {on, rw, busy, en, ack1, ack0, rs, lcd_data};

   int n_checks = 0;
   int n_pass   = 0;

   logic [14:0] exp_v [MAXC];
   bit          d_req [2][MAXC];
   bit          d_rs  [2][MAXC];
   logic [7:0]  d_dat [2][MAXC];
   int          sched_len;

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_drive(input int c);
      req0  = d_req[0][c];
      rs0   = d_rs[0][c];
      data0 = d_dat[0][c];
      req1  = d_req[1][c];
      rs1   = d_rs[1][c];
      data1 = d_dat[1][c];
   endtask

   // Transaction-level model: grants at edges, each write lasting S+P+H+wait cycles.
   task automatic build_sched(input int nt, input bit gapless);
      int rdy[2];
      int drv[2];
      int k[2];
      bit prs[2];
      logic [7:0] pdt[2];
      int idle, g, n, a, gap, dur, last_a;
      bit prio, e0, e1, clr;
      int tg[$];
      int ta[$];
      int tn[$];
      logic [8:0] tp[$];
      for (int c = 0; c < MAXC; c++) begin
         for (int r = 0; r < 2; r++) begin
            d_req[r][c] = 1'b0;
            d_rs[r][c]  = 1'($urandom_range(1, 0));
            d_dat[r][c] = 8'($urandom);
         end
         exp_v[c] = 15'h4000;
      end
      for (int r = 0; r < 2; r++) begin
         k[r]   = 0;
         drv[r] = gapless ? 0 : int'($urandom_range(3, 0));
         rdy[r] = drv[r];
         prs[r] = 1'($urandom_range(1, 0));
         pdt[r] = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(4, 0)) : 8'($urandom);
      end
      idle = 0; prio = 1'b0; last_a = 0;
      while (k[0] < nt || k[1] < nt) begin
         g = (rdy[0] < rdy[1]) ? rdy[0] : rdy[1];
         if (g < idle) g = idle;
         e0 = (rdy[0] <= g);
         e1 = (rdy[1] <= g);
         n  = (e0 && e1) ? int'(prio) : (e1 ? 1 : 0);
         for (int c = drv[n]; c <= g; c++) begin
            d_req[n][c] = 1'b1;
            d_rs[n][c]  = prs[n];
            d_dat[n][c] = pdt[n];
         end
         clr = (prs[n] == 1'b0) && (pdt[n] >= 8'h01) && (pdt[n] <= 8'h03);
         dur = S + P + H + (clr ? C : E);
         a   = g + dur + 1;
         for (int c = g + 1; c < a; c++) d_req[n][c] = 1'($urandom_range(1, 0));
         tg.push_back(g); ta.push_back(a); tn.push_back(n); tp.push_back({prs[n], pdt[n]});
         prio = (n == 0);
         idle = a;
         last_a = a;
         k[n]++;
         if (k[n] < nt) begin
            gap    = gapless ? 0 : int'($urandom_range(4, 0));
            drv[n] = a + gap;
            rdy[n] = (drv[n] > a + 1) ? drv[n] : a + 1;
            prs[n] = 1'($urandom_range(1, 0));
            pdt[n] = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(4, 0)) : 8'($urandom);
         end else begin
            rdy[n] = BIG;
         end
      end
      sched_len = last_a + 3;
      for (int i = 0; i < tg.size(); i++) begin
         for (int c = tg[i] + 1; c <= sched_len; c++) exp_v[c][8:0] = tp[i];
         for (int c = tg[i] + 1; c < ta[i]; c++) exp_v[c][12] = 1'b1;
         for (int c = tg[i] + S + 1; c <= tg[i] + S + P; c++) exp_v[c][11] = 1'b1;
         exp_v[ta[i]][9 + tn[i]] = 1'b1;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs_v !== 15'h0000) $display("FAIL reset_values got=%h exp=%h", obs_v, 15'h0000);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      n_checks++;
      if (obs_v !== 15'h0000) $display("FAIL on_before_edge got=%h exp=%h", obs_v, 15'h0000);
      else n_pass++;
      for (int c = 1; c <= 3; c++) begin
         step();
         n_checks++;
         if (obs_v !== 15'h4000) $display("FAIL idle_after_release cyc=%0d got=%h exp=%h", c, obs_v, 15'h4000);
         else n_pass++;
      end
   endtask

   task automatic test_single_write();
      logic [14:0] e;
      do_reset();
      req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
      for (int c = 1; c <= 21; c++) begin
         step();
         e = {1'b1, 1'b0, (c <= 18), (c >= 3 && c <= 6), 1'b0, (c == 19), 1'b1, 8'h41};
         n_checks++;
         if (obs_v !== e) $display("FAIL single_write cyc=%0d got=%h exp=%h", c, obs_v, e);
         else n_pass++;
         if (c < 19) begin
            rs0   = 1'($urandom_range(1, 0));
            data0 = 8'($urandom);
         end else begin
            req0 = 1'b0;
         end
      end
   endtask

   task automatic test_clear_cmd();
      logic [8:0]  tbl [7] = '{9'h001, 9'h080, 9'h002, 9'h003, 9'h000, 9'h004, 9'h101};
      int          ack_at [7] = '{49, 19, 49, 49, 19, 19, 19};
      logic [14:0] e;
      do_reset();
      for (int t = 0; t < 7; t++) begin
         req1 = 1'b1; rs1 = tbl[t][8]; data1 = tbl[t][7:0];
         for (int c = 1; c <= ack_at[t] + 1; c++) begin
            step();
            e = {1'b1, 1'b0, (c < ack_at[t]), (c >= 3 && c <= 6), (c == ack_at[t]), 1'b0, tbl[t]};
            n_checks++;
            if (obs_v !== e) $display("FAIL clear_cmd t=%0d cyc=%0d got=%h exp=%h", t, c, obs_v, e);
            else n_pass++;
            if (c == ack_at[t]) req1 = 1'b0;
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [7:0]  d0, d1;
      logic [14:0] e;
      bit          b, s;
      do_reset();
      d0 = 8'($urandom); d1 = 8'($urandom);
      req0 = 1'b1; rs0 = 1'b1; data0 = d0;
      req1 = 1'b1; rs1 = 1'b1; data1 = d1;
      for (int c = 1; c <= 40; c++) begin
         step();
         b = (c <= 18) || (c >= 20 && c <= 37);
         s = (c >= 3 && c <= 6) || (c >= 22 && c <= 25);
         e = {1'b1, 1'b0, b, s, (c == 38), (c == 19), 1'b1, (c <= 19) ? d0 : d1};
         n_checks++;
         if (obs_v !== e) $display("FAIL simultaneous cyc=%0d got=%h exp=%h", c, obs_v, e);
         else n_pass++;
         if (c == 19) req0 = 1'b0;
         if (c == 38) req1 = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0]  d;
      logic [14:0] e;
      do_reset();
      d = 8'($urandom);
      req0 = 1'b1; rs0 = 1'b1; data0 = d;
      for (int c = 1; c <= 4; c++) begin
         step();
         e = {1'b1, 1'b0, 1'b1, (c >= 3), 1'b0, 1'b0, 1'b1, d};
         n_checks++;
         if (obs_v !== e) $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", c, obs_v, e);
         else n_pass++;
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs_v !== 15'h0000) $display("FAIL reset_mid_immediate got=%h exp=%h", obs_v, 15'h0000);
      else n_pass++;
      for (int c = 5; c <= 10; c++) begin
         step();
         n_checks++;
         if (obs_v !== 15'h0000) $display("FAIL reset_mid_hold cyc=%0d got=%h exp=%h", c, obs_v, 15'h0000);
         else n_pass++;
      end
      rst_n = 1'b1;
      for (int c = 1; c <= 21; c++) begin
         step();
         e = {1'b1, 1'b0, (c <= 18), (c >= 3 && c <= 6), 1'b0, (c == 19), 1'b1, d};
         n_checks++;
         if (obs_v !== e) $display("FAIL reset_mid_restart cyc=%0d got=%h exp=%h", c, obs_v, e);
         else n_pass++;
         if (c == 19) req0 = 1'b0;
      end
   endtask

   task automatic test_fairness();
      int order[$];
      build_sched(3, 1'b1);
      do_reset();
      for (int c = 0; c <= sched_len; c++) begin
         if (c > 0) begin
            n_checks++;
            if (obs_v !== exp_v[c]) $display("FAIL fairness cyc=%0d got=%h exp=%h", c, obs_v, exp_v[c]);
            else n_pass++;
            if (obs_v[9] === 1'b1) order.push_back(0);
            if (obs_v[10] === 1'b1) order.push_back(1);
         end
         apply_drive(c);
         step();
      end
      req0 = 1'b0; req1 = 1'b0;
      n_checks++;
      if (order.size() != 6) $display("FAIL fairness_count got=%0d exp=%0d", order.size(), 6);
      else n_pass++;
      for (int i = 0; i < order.size(); i++) begin
         n_checks++;
         if (order[i] != (i % 2)) $display("FAIL fairness_order i=%0d got=%0d exp=%0d", i, order[i], i % 2);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int run = 0; run < 2; run++) begin
         build_sched(6, 1'b0);
         do_reset();
         for (int c = 0; c <= sched_len; c++) begin
            if (c > 0) begin
               n_checks++;
               if (obs_v !== exp_v[c]) $display("FAIL random run=%0d cyc=%0d got=%h exp=%h", run, c, obs_v, exp_v[c]);
               else n_pass++;
            end
            apply_drive(c);
            step();
         end
         req0 = 1'b0; req1 = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b1;
      req0 = 1'b0; rs0 = 1'b0; data0 = 8'h00;
      req1 = 1'b0; rs1 = 1'b0; data1 = 8'h00;
      #1 rst_n = 1'b0;
      test_reset();
      test_single_write();
      test_clear_cmd();
      test_simultaneous();
      test_reset_mid();
      test_fairness();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lcd_write_arbiter.md
Name: lcd_write_arbiter

Overview:
Shares the single 8-bit HD44780-style character LCD port (en, lcd_data, rs, rw, on) between two requesters, typically KPN process nodes that emit characters or commands. Round-robin arbitration selects one requester. The block then sequences one write: setup, enable pulse, hold, then a command-execution wait. When the write completes, the winning requester receives a one-cycle ack. The block sits between the KPN processes and the board LCD pins, and replaces direct drive of the LCD from a single process.

Parameters:
SETUP_CYC, 2, cycles rs/lcd_data are stable before en rises (>=1)
PULSE_CYC, 12, cycles en is held high (>=1)
HOLD_CYC, 2, cycles rs/lcd_data are held after en falls (>=1)
EXEC_CYC, 2000, wait cycles after a normal write (>=1)
CLR_CYC, 80000, wait cycles after clear/home commands (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 write request; level, held until ack0
rs0  in  1  requester 0 register select (0=command, 1=data)
data0  in  8  requester 0 byte
ack0  out  1  one-cycle pulse: requester 0 write completed
req1, rs1, data1, ack1  same as above for requester 1
en  out  1  LCD enable strobe
lcd_data  out  8  LCD data bus
rs  out  1  LCD register select
rw  out  1  LCD read/write; constant 0 (write-only)
on  out  1  LCD power/backlight on
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): en=0, lcd_data=8'h00, rs=0, rw=0, on=0, ack0=ack1=0, busy=0, state=IDLE, rr pointer=requester 0 first. Outputs take reset values immediately.
- on: registered; set to 1 on the first clk edge after rst_n deasserts and held at 1.
- States: IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> IDLE. SETUP, PULSE, HOLD and WAIT each last exactly their cycle count; a single down-counter is reloaded on each transition.
- IDLE: at a clk edge with an eligible request, grant, latch rs/data from the winner into rs/lcd_data, and go to SETUP.
- Arbitration: if only one requester is eligible, grant it. If both are eligible, grant the one not served last. The pointer updates at grant.
- Eligibility: reqN=1 and ackN not asserted in the current cycle. This masks the stale request in the ack cycle.
- SETUP: en=0. PULSE: en=1. HOLD: en=0. WAIT: en=0.
- rs/lcd_data hold their latched values from grant until the next grant; they are not cleared in IDLE.
- WAIT length is CLR_CYC when latched rs=0 and data is in {8'h01, 8'h02, 8'h03}; otherwise it is EXEC_CYC.
- Completion: on leaving WAIT, the granted ackN is high for exactly one cycle (the first IDLE cycle).
- Latency, with the grant at edge t: en high for cycles t+S+1 .. t+S+P; ack at cycle t+S+P+H+W+1.
- A grant may occur in the ack cycle (the other requester), giving back-to-back transactions with no idle gap.
- Inputs sampled only at grant: changes to rsN/dataN/reqN after grant are ignored. If reqN drops before ack, the transaction still completes and ack is still emitted.
- Reset mid-transaction: the transaction is abandoned, no ack is emitted, and en drops immediately. A requester still holding req after release is served from scratch.

Optional Feature:
LCD_INIT_EN:
- Defined: after reset release the block autonomously issues commands 8'h38, 8'h0C, 8'h06, 8'h01 with rs=0, using the same SETUP/PULSE/HOLD/WAIT timing. The final 8'h01 uses CLR_CYC.
  - No ack is emitted for these commands.
  - busy=1 throughout; requests are not granted until the sequence ends.
  - The rr pointer stays at requester 0.
- Undefined: no init sequence; arbitration starts on the first edge after reset release.

Test Plan:
Parameters for all scenarios: SETUP=2, PULSE=4, HOLD=2, EXEC=10, CLR=40.
- Single data write: req0=1, rs0=1, data0=8'h41, grant at cycle 0 -> rs=1, lcd_data=8'h41 from cycle 1; en=1 cycles 3-6; ack0 only at cycle 19; rw=0 always.
- Clear command: req1=1, rs1=0, data1=8'h01, grant at 0 -> en=1 cycles 3-6; ack1 at cycle 49. Repeat with 8'h80 -> ack1 at cycle 19.
- Simultaneous requests after reset: req0=req1=1 at cycle 0 -> requester 0 granted, ack0 at 19; requester 1 granted at 19 (ack cycle), en=1 cycles 22-25, ack1 at 38.
- Fairness: both requesters re-request immediately after each ack for 6 transactions -> grants alternate 0,1,0,1,0,1; no ack pulse wider than 1 cycle.
- Reset mid-pulse: assert rst_n=0 at cycle 4 (en=1) -> en, lcd_data, rs, on immediately 0, no ack. Release at cycle 10 with req0 still high -> full transaction restarts, on=1 one edge after release.
- With LCD_INIT_EN: req0 asserted during init -> lcd_data sequence 38,0C,06,01, each with one en pulse and no acks. Last init command 8'h01 granted at cycle 54, done (IDLE) at cycle 103. req0 granted at cycle 103, ack0 at cycle 122; busy=0 only between.
